// File: rtl/sys_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sys_writeback_arbiter
// Description : Collects the system unit's GPR, SPR and CR result streams in
//               per-channel FIFOs and serialises them round-robin onto a single
//               common-data-bus write-back port. A granted beat that is
//               stalled keeps the bus locked until it is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_writeback_arbiter #(
  parameter int RS_ID_WIDTH = 5,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   gpr_valid,
  output logic                   gpr_ready,
  input  logic [RS_ID_WIDTH-1:0] gpr_rs_id,
  input  logic [4:0]             gpr_reg_addr,
  input  logic [31:0]            gpr_value,

  input  logic                   spr_valid,
  output logic                   spr_ready,
  input  logic [RS_ID_WIDTH-1:0] spr_rs_id,
  input  logic [9:0]             spr_reg_addr,
  input  logic [31:0]            spr_value,

  input  logic                   cr_valid,
  output logic                   cr_ready,
  input  logic [RS_ID_WIDTH-1:0] cr_rs_id,
  input  logic [7:0]             cr_enable,
  input  logic [31:0]            cr_value,

  output logic                   cdb_valid,
  input  logic                   cdb_ready,
  output logic [1:0]             cdb_kind,
  output logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  output logic [9:0]             cdb_reg_addr,
  output logic [7:0]             cdb_cr_enable,
  output logic [31:0]            cdb_value
);

  localparam int NUM_CH  = 3;
  // Entry layout: {rs_id, reg_addr[9:0], cr_enable[7:0], value[31:0]}
  localparam int ENTRY_W = RS_ID_WIDTH + 10 + 8 + 32;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] CH_GPR = 2'd0;
  localparam logic [1:0] CH_SPR = 2'd1;
  localparam logic [1:0] CH_CR  = 2'd2;

  localparam logic [0:0] ST_ARB  = 1'b0;  // free to pick a new channel
  localparam logic [0:0] ST_HOLD = 1'b1;  // stalled beat pinned on the bus

  logic [NUM_CH-1:0]  chan_valid;
  logic [NUM_CH-1:0]  chan_ready;
  logic [NUM_CH-1:0]  chan_push;
  logic [NUM_CH-1:0]  chan_pop;
  logic [NUM_CH-1:0]  chan_nonempty;
  logic [ENTRY_W-1:0] chan_entry [NUM_CH];
  logic [ENTRY_W-1:0] head_entry [NUM_CH];

  logic [0:0]         state;
  logic [0:0]         state_next;
  logic [1:0]         rr_ptr;
  logic [1:0]         hold_ch;
  logic [1:0]         grant;
  logic [ENTRY_W-1:0] sel_entry;
  logic               transfer;

  // Circular pointer increment, wrapping at FIFO_DEPTH
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign chan_valid = {cr_valid, spr_valid, gpr_valid};

  // Normalise every channel to the common entry layout; unused fields are 0
  assign chan_entry[0] = {gpr_rs_id, 5'b0, gpr_reg_addr, 8'b0, gpr_value};
  assign chan_entry[1] = {spr_rs_id, spr_reg_addr, 8'b0, spr_value};
  assign chan_entry[2] = {cr_rs_id, 10'b0, cr_enable, cr_value};

  assign gpr_ready = chan_ready[0];
  assign spr_ready = chan_ready[1];
  assign cr_ready  = chan_ready[2];

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
      logic [CNT_W-1:0]   count;
      logic [PTR_W-1:0]   wr_ptr;
      logic [PTR_W-1:0]   rd_ptr;

      // Ready depends only on the registered count, so a pop never frees a
      // slot in the same cycle; it is also held low while reset is asserted.
      assign chan_ready[g]    = rst & (count != FULL_CNT);
      assign chan_push[g]     = chan_valid[g] & chan_ready[g];
      assign chan_nonempty[g] = (count != '0);
      assign head_entry[g]    = mem[rd_ptr];

      // Occupancy and pointer tracking; reset discards all buffered beats
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          count  <= '0;
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (chan_push[g]) begin
            wr_ptr <= next_ptr(wr_ptr);
          end
          if (chan_pop[g]) begin
            rd_ptr <= next_ptr(rd_ptr);
          end
          case ({chan_push[g], chan_pop[g]})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
          endcase
        end
      end

      // Entry storage; contents are meaningless while the count says empty
      always_ff @(posedge clk) begin
        if (chan_push[g]) begin
          mem[wr_ptr] <= chan_entry[g];
        end
      end
    end
  endgenerate

  assign transfer = cdb_valid & cdb_ready;

  // Lock state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_ARB;
    end else begin
      state <= state_next;
    end
  end

  // Lock next-state: enter HOLD on a stalled beat, leave on acceptance
  always_comb begin
    state_next = state;
    case (state)
      ST_ARB:  if (cdb_valid && !cdb_ready) state_next = ST_HOLD;
      ST_HOLD: if (cdb_ready) state_next = ST_ARB;
      default: state_next = ST_ARB;
    endcase
  end

  // Grant selection, CDB drive and FIFO pops
  always_comb begin
    grant         = CH_GPR;
    sel_entry     = '0;
    chan_pop      = '0;
    cdb_valid     = |chan_nonempty;
    cdb_kind      = 2'b00;
    cdb_rs_id     = '0;
    cdb_reg_addr  = '0;
    cdb_cr_enable = '0;
    cdb_value     = '0;

    if (state == ST_HOLD) begin
      grant = hold_ch;
    end else begin
      case (rr_ptr)
        CH_SPR:  grant = chan_nonempty[1] ? CH_SPR :
                         chan_nonempty[2] ? CH_CR  : CH_GPR;
        CH_CR:   grant = chan_nonempty[2] ? CH_CR  :
                         chan_nonempty[0] ? CH_GPR : CH_SPR;
        default: grant = chan_nonempty[0] ? CH_GPR :
                         chan_nonempty[1] ? CH_SPR : CH_CR;
      endcase
    end

    case (grant)
      CH_SPR:  sel_entry = head_entry[1];
      CH_CR:   sel_entry = head_entry[2];
      default: sel_entry = head_entry[0];
    endcase

    if (cdb_valid) begin
      cdb_kind      = grant;
      cdb_rs_id     = sel_entry[ENTRY_W-1 -: RS_ID_WIDTH];
      cdb_reg_addr  = sel_entry[49:40];
      cdb_cr_enable = sel_entry[39:32];
      cdb_value     = sel_entry[31:0];
      case (grant)
        CH_SPR:  chan_pop[1] = cdb_ready;
        CH_CR:   chan_pop[2] = cdb_ready;
        default: chan_pop[0] = cdb_ready;
      endcase
    end
  end

  // Round-robin pointer advances only on transfer; stalled grant is remembered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= CH_GPR;
      hold_ch <= CH_GPR;
    end else begin
      if (transfer) begin
        rr_ptr <= (grant == CH_CR) ? CH_GPR : grant + 2'd1;
      end
      if (cdb_valid && !cdb_ready) begin
        hold_ch <= grant;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_writeback_arbiter
// Description : Cycle-table bench for sys_writeback_arbiter plus hand-written
//               reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        gpr_valid, gpr_ready;
  logic [4:0]  gpr_rs_id, gpr_reg_addr;
  logic [31:0] gpr_value;
  logic        spr_valid, spr_ready;
  logic [4:0]  spr_rs_id;
  logic [9:0]  spr_reg_addr;
  logic [31:0] spr_value;
  logic        cr_valid, cr_ready;
  logic [4:0]  cr_rs_id;
  logic [7:0]  cr_enable;
  logic [31:0] cr_value;
  logic        cdb_valid, cdb_ready;
  logic [1:0]  cdb_kind;
  logic [4:0]  cdb_rs_id;
  logic [9:0]  cdb_reg_addr;
  logic [7:0]  cdb_cr_enable;
  logic [31:0] cdb_value;

  sys_writeback_arbiter #(.RS_ID_WIDTH(5), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .gpr_valid(gpr_valid), .gpr_ready(gpr_ready), .gpr_rs_id(gpr_rs_id),
    .gpr_reg_addr(gpr_reg_addr), .gpr_value(gpr_value),
    .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_rs_id(spr_rs_id),
    .spr_reg_addr(spr_reg_addr), .spr_value(spr_value),
    .cr_valid(cr_valid), .cr_ready(cr_ready), .cr_rs_id(cr_rs_id),
    .cr_enable(cr_enable), .cr_value(cr_value),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_kind(cdb_kind),
    .cdb_rs_id(cdb_rs_id), .cdb_reg_addr(cdb_reg_addr),
    .cdb_cr_enable(cdb_cr_enable), .cdb_value(cdb_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle: {valid, kind, rs_id, reg_addr, cr_enable, value, gpr/spr/cr ready}
  logic [60:0] got;
  assign got = {cdb_valid, cdb_kind, cdb_rs_id, cdb_reg_addr, cdb_cr_enable,
                cdb_value, gpr_ready, spr_ready, cr_ready};

  typedef struct packed {
    logic        gv;
    logic [4:0]  grs;
    logic [4:0]  ga;
    logic [31:0] gd;
    logic        sv;
    logic [4:0]  srs;
    logic [9:0]  sa;
    logic [31:0] sd;
    logic        cv;
    logic [4:0]  crs;
    logic [7:0]  ce;
    logic [31:0] cd;
    logic        rdy;
    logic [60:0] expv;
  } vec_t;

  vec_t tbl[$];
  vec_t cur;
  int   errors = 0;
  int   checks = 0;

  localparam logic [2:0] ALL = 3'b111;

  function automatic logic [60:0] idle(input logic [2:0] r);
    return {58'd0, r};
  endfunction

  function automatic logic [60:0] beat(input logic [1:0] k, input logic [4:0] rs,
                                       input logic [9:0] a, input logic [7:0] e,
                                       input logic [31:0] d, input logic [2:0] r);
    return {1'b1, k, rs, a, e, d, r};
  endfunction

  task automatic pg(input logic [4:0] rs, input logic [4:0] a, input logic [31:0] d);
    cur.gv = 1'b1; cur.grs = rs; cur.ga = a; cur.gd = d;
  endtask

  task automatic ps(input logic [4:0] rs, input logic [9:0] a, input logic [31:0] d);
    cur.sv = 1'b1; cur.srs = rs; cur.sa = a; cur.sd = d;
  endtask

  task automatic pc(input logic [4:0] rs, input logic [7:0] e, input logic [31:0] d);
    cur.cv = 1'b1; cur.crs = rs; cur.ce = e; cur.cd = d;
  endtask

  task automatic add(input logic r, input logic [60:0] e);
    cur.rdy = r; cur.expv = e;
    tbl.push_back(cur);
    cur = '0;
  endtask

  task automatic drive(input vec_t v);
    gpr_valid = v.gv; gpr_rs_id = v.grs; gpr_reg_addr = v.ga; gpr_value = v.gd;
    spr_valid = v.sv; spr_rs_id = v.srs; spr_reg_addr = v.sa; spr_value = v.sd;
    cr_valid  = v.cv; cr_rs_id  = v.crs; cr_enable    = v.ce; cr_value  = v.cd;
    cdb_ready = v.rdy;
  endtask

  task automatic check(input string name, input logic [60:0] e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, e);
    end
  endtask

  initial begin
    cur = '0;
    drive('0);
    rst = 1'b0;

    // ---- Table: inputs held for one cycle, outputs expected during that cycle
    // Round-robin from reset pointer (GPR)
    pg(5'd1, 5'd1, 32'h11111111); ps(5'd2, 10'h3FF, 32'h22222222); pc(5'd4, 8'h0F, 32'h33333333);
    add(1'b1, idle(ALL));                                                      // v0
    add(1'b1, beat(2'd0, 5'd1, 10'h001, 8'h00, 32'h11111111, ALL));            // v1
    add(1'b1, beat(2'd1, 5'd2, 10'h3FF, 8'h00, 32'h22222222, ALL));            // v2
    add(1'b1, beat(2'd2, 5'd4, 10'h000, 8'h0F, 32'h33333333, ALL));            // v3
    ps(5'd5, 10'h155, 32'h44444444); pc(5'd6, 8'hF0, 32'h55555555);
    add(1'b1, idle(ALL));                                                      // v4
    add(1'b1, beat(2'd1, 5'd5, 10'h155, 8'h00, 32'h44444444, ALL));            // v5
    add(1'b1, beat(2'd2, 5'd6, 10'h000, 8'hF0, 32'h55555555, ALL));            // v6
    // SPR alone moves pointer to CR; GPR+CR then comes out CR first
    ps(5'd7, 10'h002, 32'h66666666);
    add(1'b1, idle(ALL));                                                      // v7
    pg(5'd8, 5'h1F, 32'h77777777); pc(5'd9, 8'h01, 32'h88888888);
    add(1'b1, beat(2'd1, 5'd7, 10'h002, 8'h00, 32'h66666666, ALL));            // v8
    add(1'b1, beat(2'd2, 5'd9, 10'h000, 8'h01, 32'h88888888, ALL));            // v9
    add(1'b1, beat(2'd0, 5'd8, 10'h01F, 8'h00, 32'h77777777, ALL));            // v10
    add(1'b1, idle(ALL));                                                      // v11
    // Single GPR beat, one-cycle latency
    pg(5'd3, 5'd7, 32'hDEADBEEF);
    add(1'b1, idle(ALL));                                                      // v12
    add(1'b1, beat(2'd0, 5'd3, 10'd7, 8'h00, 32'hDEADBEEF, ALL));              // v13
    add(1'b1, idle(ALL));                                                      // v14
    // CR stalled 4 cycles while GPR fills up
    pc(5'd10, 8'h81, 32'h20000000);
    add(1'b0, idle(ALL));                                                      // v15
    pg(5'd11, 5'd5, 32'hAAAAAAAA);
    add(1'b0, beat(2'd2, 5'd10, 10'h000, 8'h81, 32'h20000000, ALL));           // v16
    pg(5'd12, 5'd6, 32'hBBBBBBBB);
    add(1'b0, beat(2'd2, 5'd10, 10'h000, 8'h81, 32'h20000000, ALL));           // v17
    add(1'b0, beat(2'd2, 5'd10, 10'h000, 8'h81, 32'h20000000, 3'b011));        // v18
    add(1'b0, beat(2'd2, 5'd10, 10'h000, 8'h81, 32'h20000000, 3'b011));        // v19
    add(1'b1, beat(2'd2, 5'd10, 10'h000, 8'h81, 32'h20000000, 3'b011));        // v20
    add(1'b1, beat(2'd0, 5'd11, 10'd5, 8'h00, 32'hAAAAAAAA, 3'b011));          // v21
    add(1'b1, beat(2'd0, 5'd12, 10'd6, 8'h00, 32'hBBBBBBBB, ALL));             // v22
    add(1'b1, idle(ALL));                                                      // v23
    // SPR FIFO full with bus stalled, then drained in order
    ps(5'd13, 10'h100, 32'h00000001);
    add(1'b0, idle(ALL));                                                      // v24
    ps(5'd14, 10'h101, 32'h00000002);
    add(1'b0, beat(2'd1, 5'd13, 10'h100, 8'h00, 32'h00000001, ALL));           // v25
    ps(5'd15, 10'h102, 32'h00000003);
    add(1'b0, beat(2'd1, 5'd13, 10'h100, 8'h00, 32'h00000001, 3'b101));        // v26
    ps(5'd15, 10'h102, 32'h00000003);
    add(1'b1, beat(2'd1, 5'd13, 10'h100, 8'h00, 32'h00000001, 3'b101));        // v27
    ps(5'd15, 10'h102, 32'h00000003);
    add(1'b1, beat(2'd1, 5'd14, 10'h101, 8'h00, 32'h00000002, ALL));           // v28
    add(1'b1, beat(2'd1, 5'd15, 10'h102, 8'h00, 32'h00000003, ALL));           // v29
    add(1'b1, idle(ALL));                                                      // v30

    // ---- Reset held with a valid input present
    gpr_valid = 1'b1; gpr_rs_id = 5'd9; gpr_reg_addr = 5'd9; gpr_value = 32'h12345678;
    cdb_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", idle(3'b000));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_release", idle(ALL));
    gpr_valid = 1'b0;
    @(posedge clk); #1;

    // ---- Table run
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].expv);
      @(posedge clk); #1;
    end

    // ---- Mid-operation reset with two beats buffered per channel
    cur = '0;
    pg(5'd20, 5'd3, 32'h10000001); ps(5'd21, 10'd3, 32'h20000001); pc(5'd22, 8'h33, 32'h30000001);
    cur.rdy = 1'b0;
    drive(cur);
    @(posedge clk); #1;
    gpr_value = 32'h10000002; spr_value = 32'h20000002; cr_value = 32'h30000002;
    @(posedge clk); #1;
    drive('0);
    @(negedge clk);
    check("midop_full", beat(2'd2, 5'd22, 10'h000, 8'h33, 32'h30000001, 3'b000));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midop_in_reset", idle(3'b000));
    @(posedge clk); #1;
    rst = 1'b1;
    cdb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midop_after%0d", k), idle(ALL));
      @(posedge clk); #1;
    end

    // ---- Pointer back at GPR after reset: SPR+CR must emerge SPR first
    cur = '0;
    ps(5'd2, 10'd3, 32'hCAFE0002); pc(5'd3, 8'h04, 32'hCAFE0003);
    cur.rdy = 1'b1;
    drive(cur);
    @(posedge clk); #1;
    drive('0);
    cdb_ready = 1'b1;
    @(negedge clk);
    check("post_reset_spr", beat(2'd1, 5'd2, 10'd3, 8'h00, 32'hCAFE0002, ALL));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_cr", beat(2'd2, 5'd3, 10'd0, 8'h04, 32'hCAFE0003, ALL));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_idle", idle(ALL));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
